// File: rtl/res_station.sv
// ---------------------------------------------------------------------------
// res_station -- unified reservation station of the Qu back end.
//
// Holds renamed micro-ops written by rename and captures missing source
// operands from the common data bus. Each cycle it picks the oldest entry
// whose sources are both ready and moves it into an issue register. That
// register feeds the execution stage over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every entry and the issue register
//   res_st_wr_*, wr_*   write port from rename (slot address + entry fields)
//   cdb_valid/tag/data  result broadcast used for operand wakeup
//   free_mask, full     per-slot occupancy (1 = empty) and "no free slot"
//   wr_collision        one-cycle pulse: last write targeted an occupied slot
//   issue_valid/ready   issue handshake toward execution
//   issue_payload, issue_rd_tag, issue_rs1_data, issue_rs2_data
//                       contents of the issue register
// ---------------------------------------------------------------------------
module res_station #(
    parameter int RS_DEPTH          = 16,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int UOP_WIDTH         = 32,
    parameter int TAG_WIDTH         = PHY_RF_ADDR_WIDTH,
    parameter int PAYLOAD_WIDTH     = UOP_WIDTH,
    parameter int AGE_WIDTH         = $clog2(RS_DEPTH) + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        res_st_wr_en,
    input  logic [$clog2(RS_DEPTH)-1:0] res_st_wr_addr,
    input  logic [PAYLOAD_WIDTH-1:0]    wr_payload,
    input  logic [TAG_WIDTH-1:0]        wr_rd_tag,
    input  logic [TAG_WIDTH-1:0]        wr_rs1_tag,
    input  logic [TAG_WIDTH-1:0]        wr_rs2_tag,
    input  logic                        wr_rs1_ready,
    input  logic                        wr_rs2_ready,
    input  logic [31:0]                 wr_rs1_data,
    input  logic [31:0]                 wr_rs2_data,
    input  logic                        cdb_valid,
    input  logic [TAG_WIDTH-1:0]        cdb_tag,
    input  logic [31:0]                 cdb_data,
    output logic [RS_DEPTH-1:0]         free_mask,
    output logic                        full,
    output logic                        wr_collision,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [PAYLOAD_WIDTH-1:0]    issue_payload,
    output logic [TAG_WIDTH-1:0]        issue_rd_tag,
    output logic [31:0]                 issue_rs1_data,
    output logic [31:0]                 issue_rs2_data
);

    localparam int                   IDX_W   = $clog2(RS_DEPTH);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic                 ready;
        logic [31:0]          data;
    } src_t;

    typedef struct packed {
        logic                     valid;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [TAG_WIDTH-1:0]     rd_tag;
        src_t                     rs1;
        src_t                     rs2;
        logic [AGE_WIDTH-1:0]     age;
    } entry_t;

    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];

    logic                     issue_valid_q,   issue_valid_d;
    logic [PAYLOAD_WIDTH-1:0] issue_payload_q, issue_payload_d;
    logic [TAG_WIDTH-1:0]     issue_rd_tag_q,  issue_rd_tag_d;
    logic [31:0]              issue_rs1_q,     issue_rs1_d;
    logic [31:0]              issue_rs2_q,     issue_rs2_d;
    logic                     wr_collision_q,  wr_collision_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [AGE_WIDTH-1:0] sel_age;
    logic                 issue_load;

    // A source still waiting on its tag captures a matching broadcast.
    // The same function serves stored entries and the incoming write,
    // which gives the write/CDB bypass for free.
    function automatic src_t wake(input src_t s);
        wake = s;
        if (cdb_valid && !s.ready && (s.tag == cdb_tag)) begin
            wake.ready = 1'b1;
            wake.data  = cdb_data;
        end
    endfunction

    // Oldest-ready select. Strict '>' keeps the lowest index on an age tie.
    always_comb begin
        // NOTE: every variable assigned in an always_comb gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].rs1.ready && ent_q[i].rs2.ready &&
                (!sel_found || ent_q[i].age > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_q[i].age;
            end
        end
    end

    assign issue_load = sel_found && (!issue_valid_q || issue_ready) && !flush;

    // Per-slot next state: free on issue, else wake up and age; empty
    // slots accept a write. Flush overrides everything.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                if (issue_load && (sel_idx == IDX_W'(i))) begin
                    ent_d[i].valid = 1'b0;
                end else begin
                    ent_d[i].rs1 = wake(ent_q[i].rs1);
                    ent_d[i].rs2 = wake(ent_q[i].rs2);
                    if (ent_q[i].age != AGE_MAX) begin
                        ent_d[i].age = ent_q[i].age + 1'b1;
                    end
                end
            end else if (res_st_wr_en && (res_st_wr_addr == IDX_W'(i))) begin
                ent_d[i].valid   = 1'b1;
                ent_d[i].payload = wr_payload;
                ent_d[i].rd_tag  = wr_rd_tag;
                ent_d[i].rs1     = wake({wr_rs1_tag, wr_rs1_ready, wr_rs1_data});
                ent_d[i].rs2     = wake({wr_rs2_tag, wr_rs2_ready, wr_rs2_data});
                ent_d[i].age     = '0;
            end
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    // Issue register: contents are frozen once loaded; only a new load
    // changes them. A consumed entry with nothing behind it drops valid.
    always_comb begin
        issue_valid_d   = issue_valid_q;
        issue_payload_d = issue_payload_q;
        issue_rd_tag_d  = issue_rd_tag_q;
        issue_rs1_d     = issue_rs1_q;
        issue_rs2_d     = issue_rs2_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (issue_load) begin
            issue_valid_d   = 1'b1;
            issue_payload_d = ent_q[sel_idx].payload;
            issue_rd_tag_d  = ent_q[sel_idx].rd_tag;
            issue_rs1_d     = ent_q[sel_idx].rs1.data;
            issue_rs2_d     = ent_q[sel_idx].rs2.data;
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    assign wr_collision_d = res_st_wr_en && ent_q[res_st_wr_addr].valid && !flush;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            // NOTE: the whole entry array is cleared, not only the valid
            // bits, so reset leaves no stale operand data behind.
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q   <= 1'b0;
            issue_payload_q <= '0;
            issue_rd_tag_q  <= '0;
            issue_rs1_q     <= '0;
            issue_rs2_q     <= '0;
            wr_collision_q  <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            issue_valid_q   <= issue_valid_d;
            issue_payload_q <= issue_payload_d;
            issue_rd_tag_q  <= issue_rd_tag_d;
            issue_rs1_q     <= issue_rs1_d;
            issue_rs2_q     <= issue_rs2_d;
            wr_collision_q  <= wr_collision_d;
        end
    end

    always_comb begin
        free_mask = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_mask[i] = !ent_q[i].valid;
        end
    end

    assign full           = ~|free_mask;
    assign wr_collision   = wr_collision_q;
    assign issue_valid    = issue_valid_q;
    assign issue_payload  = issue_payload_q;
    assign issue_rd_tag   = issue_rd_tag_q;
    assign issue_rs1_data = issue_rs1_q;
    assign issue_rs2_data = issue_rs2_q;

endmodule

// File: tb/tb_res_station.sv
// ---------------------------------------------------------------------------
// tb_res_station -- self-checking bench for res_station.
//
// A reference model tracks entries as (fields, write timestamp) and derives
// age from the cycle count; a compare process checks every output on the
// falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_res_station;

    localparam int D    = 16;
    localparam int TW   = 6;
    localparam int PW   = 32;
    localparam int AMAX = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          res_st_wr_en;
    logic [3:0]    res_st_wr_addr;
    logic [PW-1:0] wr_payload;
    logic [TW-1:0] wr_rd_tag, wr_rs1_tag, wr_rs2_tag;
    logic          wr_rs1_ready, wr_rs2_ready;
    logic [31:0]   wr_rs1_data, wr_rs2_data;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic [D-1:0]  free_mask;
    logic          full, wr_collision, issue_valid, issue_ready;
    logic [PW-1:0] issue_payload;
    logic [TW-1:0] issue_rd_tag;
    logic [31:0]   issue_rs1_data, issue_rs2_data;

    res_station #(.RS_DEPTH(D), .PHY_RF_ADDR_WIDTH(TW), .UOP_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .res_st_wr_en(res_st_wr_en), .res_st_wr_addr(res_st_wr_addr),
        .wr_payload(wr_payload), .wr_rd_tag(wr_rd_tag),
        .wr_rs1_tag(wr_rs1_tag), .wr_rs2_tag(wr_rs2_tag),
        .wr_rs1_ready(wr_rs1_ready), .wr_rs2_ready(wr_rs2_ready),
        .wr_rs1_data(wr_rs1_data), .wr_rs2_data(wr_rs2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .free_mask(free_mask), .full(full), .wr_collision(wr_collision),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_payload(issue_payload), .issue_rd_tag(issue_rd_tag),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_v  [D];
    logic [PW-1:0] m_pl [D];
    logic [TW-1:0] m_rd [D];
    logic [TW-1:0] m_t1 [D], m_t2 [D];
    bit            m_r1 [D], m_r2 [D];
    logic [31:0]   m_d1 [D], m_d2 [D];
    int            m_t0 [D];
    int            m_cyc = 0;
    bit            m_iv, m_col;
    logic [PW-1:0] m_ipl;
    logic [TW-1:0] m_ird;
    logic [31:0]   m_id1, m_id2;

    function automatic logic [D-1:0] m_free();
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[i] = !m_v[i];
        return r;
    endfunction

    always @(posedge clk) begin : model
        int best, best_age, a, wa;
        if (rst) begin
            for (int i = 0; i < D; i++) m_v[i] = 1'b0;
            m_iv = 1'b0; m_col = 1'b0;
            m_ipl = '0; m_ird = '0; m_id1 = '0; m_id2 = '0;
        end else if (flush) begin
            for (int i = 0; i < D; i++) m_v[i] = 1'b0;
            m_iv = 1'b0; m_col = 1'b0;
        end else begin
            wa = int'(res_st_wr_addr);
            m_col = res_st_wr_en && m_v[wa];
            best = -1; best_age = -1;
            for (int i = 0; i < D; i++) begin
                if (m_v[i] && m_r1[i] && m_r2[i]) begin
                    a = m_cyc - m_t0[i];
                    if (a > AMAX) a = AMAX;
                    if (a > best_age) begin best = i; best_age = a; end
                end
            end
            if (best >= 0 && (!m_iv || issue_ready)) begin
                m_iv = 1'b1; m_ipl = m_pl[best]; m_ird = m_rd[best];
                m_id1 = m_d1[best]; m_id2 = m_d2[best];
                m_v[best] = 1'b0;
            end else if (issue_ready) begin
                m_iv = 1'b0;
            end
            if (cdb_valid) begin
                for (int i = 0; i < D; i++) begin
                    if (m_v[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_d1[i] = cdb_data; end
                    if (m_v[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_d2[i] = cdb_data; end
                end
            end
            if (res_st_wr_en && !m_col) begin
                m_v[wa] = 1'b1; m_pl[wa] = wr_payload; m_rd[wa] = wr_rd_tag;
                m_t1[wa] = wr_rs1_tag; m_r1[wa] = wr_rs1_ready; m_d1[wa] = wr_rs1_data;
                m_t2[wa] = wr_rs2_tag; m_r2[wa] = wr_rs2_ready; m_d2[wa] = wr_rs2_data;
                if (cdb_valid && !wr_rs1_ready && wr_rs1_tag == cdb_tag) begin m_r1[wa] = 1'b1; m_d1[wa] = cdb_data; end
                if (cdb_valid && !wr_rs2_ready && wr_rs2_tag == cdb_tag) begin m_r2[wa] = 1'b1; m_d2[wa] = cdb_data; end
                m_t0[wa] = m_cyc + 1;
            end
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp.issue_valid", 64'(issue_valid), 64'(m_iv));
            check("cmp.free_mask", 64'(free_mask), 64'(m_free()));
            check("cmp.full", 64'(full), 64'(m_free() == '0));
            check("cmp.wr_collision", 64'(wr_collision), 64'(m_col));
            if (m_iv) begin
                check("cmp.issue_payload", 64'(issue_payload), 64'(m_ipl));
                check("cmp.issue_rd_tag", 64'(issue_rd_tag), 64'(m_ird));
                check("cmp.issue_rs1_data", 64'(issue_rs1_data), 64'(m_id1));
                check("cmp.issue_rs2_data", 64'(issue_rs2_data), 64'(m_id2));
            end
        end
    end

    // Accepted issues, in order, for the literal ordering checks.
    logic [31:0] log_q[$];
    always @(posedge clk) begin
        if (!rst && issue_valid && issue_ready) log_q.push_back(issue_payload);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [31:0] pl, input logic [TW-1:0] rd,
                      input logic [TW-1:0] t1, input logic r1, input logic [31:0] d1,
                      input logic [TW-1:0] t2, input logic r2, input logic [31:0] d2);
        res_st_wr_en = 1'b1; res_st_wr_addr = addr[3:0];
        wr_payload = pl; wr_rd_tag = rd;
        wr_rs1_tag = t1; wr_rs1_ready = r1; wr_rs1_data = d1;
        wr_rs2_tag = t2; wr_rs2_ready = r2; wr_rs2_data = d2;
        tick();
        res_st_wr_en = 1'b0;
    endtask

    task automatic wr_rdy(input int addr, input logic [31:0] pl, input logic [TW-1:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2);
        wr(addr, pl, rd, '0, 1'b1, d1, '0, 1'b1, d2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; res_st_wr_en = 1'b0; res_st_wr_addr = '0;
        wr_payload = '0; wr_rd_tag = '0; wr_rs1_tag = '0; wr_rs2_tag = '0;
        wr_rs1_ready = 1'b0; wr_rs2_ready = 1'b0; wr_rs1_data = '0; wr_rs2_data = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst.free_mask", 64'(free_mask), 64'hFFFF);
        check("rst.full", 64'(full), 64'h0);
        check("rst.wr_collision", 64'(wr_collision), 64'h0);
        check("rst.issue_valid", 64'(issue_valid), 64'h0);
        check("rst.issue_rs1_data", 64'(issue_rs1_data), 64'h0);
        check("rst.issue_payload", 64'(issue_payload), 64'h0);
        rst = 1'b0; cmp_en = 1'b1;

        // Ready write to slot 3 issues two edges later
        issue_ready = 1'b1;
        wr_rdy(3, 32'hA3, 6'd5, 32'h11, 32'h22);
        check("t1.free_mask_busy", 64'(free_mask), 64'hFFF7);
        check("t1.not_yet", 64'(issue_valid), 64'h0);
        tick();
        check("t1.issue_valid", 64'(issue_valid), 64'h1);
        check("t1.rs1", 64'(issue_rs1_data), 64'h11);
        check("t1.rs2", 64'(issue_rs2_data), 64'h22);
        check("t1.rd_tag", 64'(issue_rd_tag), 64'h5);
        check("t1.free_mask", 64'(free_mask), 64'hFFFF);
        tick();

        // CDB wakeup after the write
        wr(0, 32'hB0, 6'd1, 6'd9, 1'b0, 32'h0, 6'd3, 1'b1, 32'h33);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
        tick();
        cdb_valid = 1'b0;
        check("t2.not_yet", 64'(issue_valid), 64'h0);
        tick();
        check("t2.issue_valid", 64'(issue_valid), 64'h1);
        check("t2.rs1", 64'(issue_rs1_data), 64'hDEAD);
        check("t2.rs2", 64'(issue_rs2_data), 64'h33);
        tick();

        // Write/CDB bypass in the same cycle
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hBEEF;
        wr(1, 32'hC1, 6'd2, 6'd7, 1'b0, 32'h0, 6'd4, 1'b1, 32'h44);
        cdb_valid = 1'b0;
        tick();
        check("t3.issue_valid", 64'(issue_valid), 64'h1);
        check("t3.rs1", 64'(issue_rs1_data), 64'hBEEF);
        tick();

        // Both sources woken by one broadcast
        wr(5, 32'hD5, 6'd3, 6'd12, 1'b0, 32'h0, 6'd12, 1'b0, 32'h0);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h5555;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("t3b.rs1", 64'(issue_rs1_data), 64'h5555);
        check("t3b.rs2", 64'(issue_rs2_data), 64'h5555);
        tick();

        // Fill all slots under back-pressure, then drain oldest first
        issue_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < D; i++) wr_rdy(i, 32'h100 + i, TW'(i), 32'h1000 + i, 32'h2000 + i);
        check("t4.free_mask_one", 64'(free_mask), 64'h0001);
        check("t4.held_payload", 64'(issue_payload), 64'h100);
        wr_rdy(0, 32'h110, 6'd16, 32'h1010, 32'h2010);
        check("t4.full", 64'(full), 64'h1);
        check("t4.free_mask_zero", 64'(free_mask), 64'h0);
        repeat (3) begin
            tick();
            check("t4.stall_valid", 64'(issue_valid), 64'h1);
            check("t4.stall_payload", 64'(issue_payload), 64'h100);
            check("t4.stall_rs1", 64'(issue_rs1_data), 64'h1000);
        end
        issue_ready = 1'b1;
        repeat (17) tick();
        check("t4.issue_count", 64'(log_q.size()), 64'd17);
        for (int k = 0; k < 17; k++) begin
            if (k < log_q.size()) check("t4.order", 64'(log_q[k]), 64'(32'h100 + k));
        end
        check("t4.drained", 64'(issue_valid), 64'h0);
        check("t4.empty", 64'(free_mask), 64'hFFFF);

        // Write collision on occupied slot 2
        issue_ready = 1'b0;
        log_q.delete();
        wr_rdy(0, 32'hA0, 6'd8, 32'h0A, 32'h0B);
        wr_rdy(2, 32'h222, 6'd9, 32'h2A, 32'h2B);
        wr_rdy(2, 32'h333, 6'd10, 32'h3A, 32'h3B);
        check("t5.collision", 64'(wr_collision), 64'h1);
        check("t5.free_mask", 64'(free_mask), 64'hFFFB);
        tick();
        check("t5.collision_pulse", 64'(wr_collision), 64'h0);
        issue_ready = 1'b1;
        repeat (3) tick();
        check("t5.issue_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            check("t5.first", 64'(log_q[0]), 64'hA0);
            check("t5.original", 64'(log_q[1]), 64'h222);
        end

        // Flush with 5 valid entries and a full issue register
        issue_ready = 1'b0;
        log_q.delete();
        for (int i = 4; i < 10; i++) wr_rdy(i, 32'h600 + i, TW'(i), 32'h6000 + i, 32'h7000 + i);
        check("t6.free_mask", 64'(free_mask), 64'hFC1F);
        check("t6.issue_valid", 64'(issue_valid), 64'h1);
        flush = 1'b1;
        wr_rdy(10, 32'h60A, 6'd11, 32'h1, 32'h2);
        flush = 1'b0;
        check("t6.flush_valid", 64'(issue_valid), 64'h0);
        check("t6.flush_mask", 64'(free_mask), 64'hFFFF);
        check("t6.flush_collision", 64'(wr_collision), 64'h0);
        issue_ready = 1'b1;
        repeat (5) tick();
        check("t6.no_issue", 64'(log_q.size()), 64'd0);
        check("t6.still_idle", 64'(issue_valid), 64'h0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/res_station.md
# res_station

Unified reservation station of the Qu processor back end; the receiving end of the rename stage's reservation-station write port. Buffers renamed micro-ops and captures pending source operands from the common data bus (CDB). Issues one fully-ready entry per cycle, oldest first, to the execution stage over a valid/ready handshake. Exports per-slot occupancy so rename can choose a free write address.

## Interface
- RS_DEPTH, 16, number of entries (power of two, ≥ 2)
- TAG_WIDTH, PHY_RF_ADDR_WIDTH, physical register tag width
- PAYLOAD_WIDTH, UOP_WIDTH, opaque micro-op payload carried to issue
- AGE_WIDTH, $clog2(RS_DEPTH)+2, per-entry age counter width

Ports:
- clk  in  1  clock (only clock)
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and the issue register
- res_st_wr_en  in  1  write strobe from rename
- res_st_wr_addr  in  $clog2(RS_DEPTH)  target slot
- wr_payload  in  PAYLOAD_WIDTH  micro-op
- wr_rd_tag  in  TAG_WIDTH  destination physical tag
- wr_rs1_tag, wr_rs2_tag  in  TAG_WIDTH  source tags
- wr_rs1_ready, wr_rs2_ready  in  1  operand already valid
- wr_rs1_data, wr_rs2_data  in  32  operand values (meaningful when ready)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_WIDTH  broadcast tag
- cdb_data  in  32  broadcast value
- free_mask  out  RS_DEPTH  bit i = 1 when slot i is empty
- full  out  1  no free slot
- wr_collision  out  1  one-cycle pulse: write hit an occupied slot
- issue_valid  out  1  issue register holds an entry
- issue_ready  in  1  execution stage accepts
- issue_payload  out  PAYLOAD_WIDTH
- issue_rd_tag  out  TAG_WIDTH
- issue_rs1_data, issue_rs2_data  out  32

## Operation
- Entry state: valid, payload, rd_tag, per source {tag, ready, data}, age.
- Write: if slot empty, store fields, valid=1, age=0. If slot occupied: entry unchanged, wr_collision=1 next cycle.
- Write/CDB bypass: if cdb_valid and cdb_tag equals a not-ready incoming source tag, that source is stored ready with cdb_data.
- Wakeup: every valid entry whose source is not ready and whose tag equals cdb_tag (cdb_valid=1) sets ready and captures cdb_data. Both sources may wake on the same broadcast.
- Age: each valid entry increments age every cycle, saturating at 2^AGE_WIDTH-1.
- Select (combinational, from registered state): candidates are valid entries with both sources ready. Choose greatest age; ties go to lowest index.
- Issue register loads when (!issue_valid || issue_ready) and a candidate exists. The selected entry is freed in the same edge. When empty or consumed with no candidate, issue_valid falls.
- Data in the issue register is frozen; CDB does not update it.
- free_mask/full are registered state: slot freed by issue shows free the next cycle. A slot freed and written in the same cycle is not possible, because rename only targets slots already shown free.
- flush: all valid=0 and issue_valid=0 next cycle. Flush takes priority over a write and a load in the same cycle. wr_collision is not raised.

## Timing
- Reset values: every entry invalid, free_mask all ones, full=0, wr_collision=0, issue_valid=0, issue data/tag/payload zero.
- Write with both sources ready at edge N: eligible in cycle N+1, issue_valid=1 after edge N+1 if the issue register is free.
- CDB wakeup at edge N: entry eligible in cycle N+1; same latency as a write.
- Throughput: one issue per cycle with issue_ready held high.
- Back-pressure: issue_valid high with issue_ready low holds all issue outputs stable; no entry is freed.
- Reset or flush mid-operation discards pending entries; there is no partial state.

## Test plan
- Reset, then write slot 3 (rs1/rs2 ready, 0x11/0x22, rd_tag 5) -> issue_valid two edges later with data 0x11/0x22, rd_tag 5; free_mask back to 0xFFFF.
- Write slot 0 with rs1 tag 9 not ready, then cdb {9, 0xDEAD} -> issue the cycle after the following edge with rs1_data 0xDEAD.
- Write carrying not-ready tag 7 in the same cycle as cdb {7, 0xBEEF} -> entry stored ready; issues with 0xBEEF.
- Fill all 16 slots ready, hold issue_ready=0 -> full=1, issue outputs stable. Release -> 16 consecutive issues in write order (oldest first).
- Write to an occupied slot 2 -> wr_collision pulses one cycle; original entry issues unchanged.
- Flush with 5 valid entries and issue_valid=1 -> next cycle issue_valid=0, free_mask=0xFFFF, no further issues.
